heap_arbiter: RTL
=================

Name: heap_arbiter

Overview:
- Shares one heap_medium instance between CLIENTS requesters (e.g. cpu, weight loader, DMA) with round-robin fairness.
- Accepts one full-width (PIECES*BRAM_WIDTH) read or write at a time.
- Issues a single-cycle read_enable/write_enable to the medium, waits for finished_out, then returns data and a done pulse to the granted client.
- Sits between the client ports and the medium's cpu-side port; the medium's BRAM side is untouched.

Parameters:
- CLIENTS, 3, number of requesters (>=1).
- ADDRS, 256, medium word count; ADDR_SIZE = $clog2(ADDRS).
- BRAM_WIDTH, 64, BRAM word width.
- PIECES, 16, BRAM words per medium word; WIDTH = PIECES*BRAM_WIDTH.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-high reset.
- req_in  input  CLIENTS  per-client request, held high until that client's done_out pulse.
- we_in  input  CLIENTS  per-client 1=write, 0=read; valid with req_in.
- addr_in  input  CLIENTS*ADDR_SIZE  packed addresses; client i at [i*ADDR_SIZE +: ADDR_SIZE].
- data_in  input  CLIENTS*WIDTH  packed write data; client i at [i*WIDTH +: WIDTH].
- data_out  output  WIDTH  read data of the most recently completed read (shared by all clients).
- done_out  output  CLIENTS  one-hot, single-cycle completion pulse.
- busy_out  output  1  high whenever state != IDLE.
- mem_addr  output  ADDR_SIZE  to medium addr_in.
- mem_data_in  output  WIDTH  to medium data_in.
- mem_data_out  input  WIDTH  from medium data_out.
- mem_read_enable  output  1  to medium read_enable.
- mem_write_enable  output  1  to medium write_enable.
- mem_finished  input  1  from medium finished_out.

Behaviour:
- All outputs are registered.
- Reset (async, any state): state=IDLE; done_out=0, data_out=0, busy_out=0, mem_* outputs=0; rr pointer=CLIENTS-1, so client 0 wins the first contest.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req_in is high, pick grant g = first set bit searching from pointer+1 upward, wrapping modulo CLIENTS.
  - Latch addr/data/we of g into mem_addr, mem_data_in and a we register; go ISSUE.
  - If no request, stay in IDLE.
- ISSUE (exactly 1 cycle): mem_read_enable=~we or mem_write_enable=we; go WAIT.
- WAIT:
  - Both enables low; mem_addr and mem_data_in held stable.
  - On mem_finished=1: if read, data_out<=mem_data_out; go DONE.
- DONE (1 cycle): done_out[g]=1; pointer<=g; go IDLE.
- Latency: req seen in IDLE at cycle n -> enable high in n+1 -> finished at cycle m>=n+2 -> done_out and data_out valid in cycle m+1 -> IDLE at m+2.
- Minimum turnaround is 4 cycles plus the medium's latency.
- Request rules:
  - A client drops req_in on the edge after sampling done_out.
  - A req_in still high when IDLE evaluates is a new request (back-to-back is legal).
  - req/we/addr/data changes while not granted are ignored until arbitration.
  - Changes by the granted client after the IDLE latch have no effect.
  - Deasserting req before done is illegal; the transaction completes regardless.
- mem_finished is ignored in IDLE, ISSUE and DONE.
- Write completion pulses done_out but leaves data_out unchanged.
- Simultaneous requests: strict round-robin; the client just served has lowest priority next arbitration.
- CLIENTS=1: pointer is constant; the FSM behaves identically.
- Reset mid-WAIT: the transaction is abandoned and no done_out fires. The medium shares rst_in, so no stale finished can follow.

Decomposition:
- Package heap_pkg:
  - heap_arb_state_t enum {IDLE, ISSUE, WAIT, DONE}.
  - Helper function heap_addr_size(ADDRS) returning $clog2.
- Sub-module rr_pick (combinational): inputs req vector and pointer; outputs one-hot grant and its index. Reused by future medium arbiters.

Test Plan:
- Single read: preload addr 5 = 0xA5.., client 1 req read addr 5 -> one mem_read_enable pulse with mem_addr=5; done_out=3'b010 one cycle after mem_finished; data_out=0xA5...
- Write then read: client 0 writes addr 17 = pattern P -> done_out[0]; then client 2 reads addr 17 -> data_out=P; data_out unchanged after the write's done.
- Fairness: all three clients hold req continuously from reset -> grant order 0,1,2,0,1,2 across six completions; each done_out one-hot.
- Back-to-back: client 0 keeps req high while client 1 requests -> order 0,1,0, never 0,0.
- Reset mid-WAIT: assert rst_in during WAIT -> all outputs 0 immediately, no done_out; a subsequent client 2 request completes normally with pointer reset (client 0 would win a tie).
- Spurious finished: drive mem_finished in IDLE and ISSUE -> no state change, no done_out.

Source files
------------

// File: rtl/heap_pkg.sv
// Shared types and helpers for the heap medium arbiters.
package heap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } heap_arb_state_t;

    function automatic int heap_addr_size(input int addrs);
        return $clog2(addrs);
    endfunction

endpackage

// File: rtl/heap_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request strictly after the pointer, wrapping.
module rr_pick #(
    parameter  int N  = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int   c_s;
    logic hit_s;
    logic found_s;

    // Scan offsets 1..N from the pointer; every client index is visited exactly once.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        c_s     = 0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            c_s          = (int'(ptr_i) + k) % N;
            hit_s        = req_i[c_s] && !found_s;
            grant_o[c_s] = hit_s;
            idx_o        = hit_s ? IW'(c_s) : idx_o;
            found_s      = found_s | hit_s;
        end
        valid_o = found_s;
    end

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one heap_medium cpu-side port among several clients.
module heap_arbiter
    import heap_pkg::*;
#(
    parameter  int CLIENTS    = 3,
    parameter  int ADDRS      = 256,
    parameter  int BRAM_WIDTH = 64,
    parameter  int PIECES     = 16,
    localparam int ADDR_SIZE  = heap_addr_size(ADDRS),
    localparam int WIDTH      = PIECES * BRAM_WIDTH,
    localparam int IW         = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CLIENTS-1:0]           req_in,
    input  logic [CLIENTS-1:0]           we_in,
    input  logic [CLIENTS*ADDR_SIZE-1:0] addr_in,
    input  logic [CLIENTS*WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic [CLIENTS-1:0]           done_out,
    output logic                         busy_out,
    output logic [ADDR_SIZE-1:0]         mem_addr,
    output logic [WIDTH-1:0]             mem_data_in,
    input  logic [WIDTH-1:0]             mem_data_out,
    output logic                         mem_read_enable,
    output logic                         mem_write_enable,
    input  logic                         mem_finished
);

    localparam logic [IW-1:0] PTR_RESET = IW'(CLIENTS - 1);

    heap_arb_state_t      state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d, gidx_q, gidx_d;
    logic [CLIENTS-1:0]   grant_q, grant_d, done_q, done_d;
    logic                 we_q, we_d, rd_en_q, rd_en_d, wr_en_q, wr_en_d, busy_q, busy_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic [CLIENTS-1:0]   pick_grant_s;
    logic [IW-1:0]        pick_idx_s;
    logic                 pick_valid_s;

    rr_pick #(.N(CLIENTS)) u_pick (
        .req_i   (req_in),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_finished only matters while waiting.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pick_valid_s ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = mem_finished ? DONE : WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched transaction.
    always_comb begin
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        done_d  = '0;
        busy_d  = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    gidx_d  = pick_idx_s;
                    grant_d = pick_grant_s;
                    we_d    = we_in[pick_idx_s];
                    addr_d  = addr_in[int'(pick_idx_s) * ADDR_SIZE +: ADDR_SIZE];
                    wdata_d = data_in[int'(pick_idx_s) * WIDTH +: WIDTH];
                    rd_en_d = ~we_in[pick_idx_s];
                    wr_en_d = we_in[pick_idx_s];
                end else begin
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end
            end
            ISSUE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
            end
            WAIT: begin
                // done is raised here so that it is visible during DONE.
                if (mem_finished) begin
                    done_d  = grant_q;
                    rdata_d = we_q ? rdata_q : mem_data_out;
                end else begin
                    done_d  = '0;
                end
            end
            DONE:    ptr_d = gidx_q;
            default: ptr_d = ptr_q;
        endcase
    end

    // Output and transaction registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr_q   <= PTR_RESET;
            gidx_q  <= '0;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign data_out         = rdata_q;
    assign done_out         = done_q;
    assign busy_out         = busy_q;
    assign mem_addr         = addr_q;
    assign mem_data_in      = wdata_q;
    assign mem_read_enable  = rd_en_q;
    assign mem_write_enable = wr_en_q;

endmodule
